neural_net_seq: RTL and testbench

Time-multiplexed, parametrised successor to the fully combinational two-layer mine-detection network. A single signed MAC datapath evaluates the hidden layer (ReLU) and then the output layer for one feature vector. Weights and biases come from a loadable internal store, and valid/ready handshakes sit on the sample input and the result output. It replaces the combinational network at the classifier boundary: the sonar-sample buffer feeds it, and the detection logic consumes the result.

---
 rtl/neural_net_seq.sv | 209 ++++++++++++++++++++
 tb/tb_neural_net_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neural_net_seq.sv
// neural_net_seq: time-multiplexed two-layer classifier (N_IN -> N_HID ReLU -> N_OUT).
// One signed MAC evaluates every neuron in turn; weights and biases sit in a loadable store.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   uzorak / _valid / _ready     feature vector in (feature i at [i*W +: W]), handshake
//   wt_we, wt_addr, wt_data      weight/bias write port, honoured only while idle
//   wt_drop                      sticky flag: an in-range write arrived while busy
//   izlaz / indikator            output-neuron values and their sign bits
//   izlaz_valid / izlaz_ready    result handshake
module neural_net_seq #(
  parameter int unsigned N_IN  = 60,
  parameter int unsigned N_HID = 5,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned NW    = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1),
  parameter int unsigned AW    = $clog2(NW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_IN*W-1:0]  uzorak,
  input  logic               uzorak_valid,
  output logic               uzorak_ready,
  input  logic               wt_we,
  input  logic [AW-1:0]      wt_addr,
  input  logic [W-1:0]       wt_data,
  output logic               wt_drop,
  output logic [N_OUT*W-1:0] izlaz,
  output logic [N_OUT-1:0]   indikator,
  output logic               izlaz_valid,
  input  logic               izlaz_ready
);

  localparam int unsigned CW  = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
  localparam int unsigned NCW = $clog2(((N_HID > N_OUT) ? N_HID : N_OUT) + 1);
  localparam int unsigned XIW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned HIW = (N_HID > 1) ? $clog2(N_HID) : 1;

  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StHid, StOut, StHold} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [CW-1:0]            i_q, i_d;
  logic [NCW-1:0]           n_q, n_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [W-1:0]      x_q [N_IN];
  logic signed [W-1:0]      x_d [N_IN];
  logic signed [W-1:0]      hid_q [N_HID];
  logic signed [W-1:0]      hid_d [N_HID];
  logic signed [W-1:0]      izl_q [N_OUT];
  logic signed [W-1:0]      izl_d [N_OUT];
  logic                     wt_drop_q, wt_drop_d;

  // Weight store: deliberately not reset, survives aborts.
  logic signed [W-1:0]      mem [NW];
  logic                     mem_we;

  logic                     wt_in_range;
  logic signed [W-1:0]      w_rd;
  logic signed [W-1:0]      op;
  logic signed [2*W-1:0]    prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  sh;
  logic signed [W-1:0]      sat;

  assign wt_in_range = ({1'b0, wt_addr} < (AW+1)'(NW));

  // The weight map is laid out in evaluation order, so a single incrementing
  // address walks every weight and bias exactly once per sample.
  assign w_rd = mem[addr_q];

  always_comb begin
    op = (state_q == StHid) ? x_q[XIW'(i_q)] : hid_q[HIW'(i_q)];
    prod     = op * w_rd;
    prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    bias_ext = $signed({{(ACC_W-W){w_rd[W-1]}}, w_rd}) <<< FRAC;
    sum      = acc_q + bias_ext;
    sh       = sum >>> FRAC;
    if (sh > SatMax) begin
      sat = {1'b0, {(W-1){1'b1}}};
    end else if (sh < SatMin) begin
      sat = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat = sh[W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    i_d       = i_q;
    n_d       = n_q;
    acc_d     = acc_q;
    x_d       = x_q;
    hid_d     = hid_q;
    izl_d     = izl_q;
    wt_drop_d = wt_drop_q;
    mem_we    = 1'b0;

    if (wt_we && wt_in_range) begin
      if (state_q == StIdle) mem_we = 1'b1;
      else                   wt_drop_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (uzorak_valid) begin
          for (int k = 0; k < int'(N_IN); k++) x_d[k] = uzorak[k*W +: W];
          addr_d  = '0;
          i_d     = '0;
          n_d     = '0;
          acc_d   = '0;
          state_d = StHid;
        end
      end
      StHid: begin
        addr_d = addr_q + 1'b1;
        if (i_q == CW'(N_IN)) begin
          for (int k = 0; k < int'(N_HID); k++) begin
            if (n_q == NCW'(k)) hid_d[k] = sat[W-1] ? '0 : sat;
          end
          acc_d = '0;
          i_d   = '0;
          if (n_q == NCW'(N_HID - 1)) begin
            n_d     = '0;
            state_d = StOut;
          end else begin
            n_d = n_q + 1'b1;
          end
        end else begin
          acc_d = acc_q + prod_ext;
          i_d   = i_q + 1'b1;
        end
      end
      StOut: begin
        addr_d = addr_q + 1'b1;
        if (i_q == CW'(N_HID)) begin
          for (int k = 0; k < int'(N_OUT); k++) begin
            if (n_q == NCW'(k)) izl_d[k] = sat;
          end
          acc_d = '0;
          i_d   = '0;
          if (n_q == NCW'(N_OUT - 1)) begin
            n_d     = '0;
            state_d = StHold;
          end else begin
            n_d = n_q + 1'b1;
          end
        end else begin
          acc_d = acc_q + prod_ext;
          i_d   = i_q + 1'b1;
        end
      end
      StHold: begin
        if (izlaz_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      i_q       <= '0;
      n_q       <= '0;
      acc_q     <= '0;
      wt_drop_q <= 1'b0;
      for (int k = 0; k < int'(N_IN); k++)  x_q[k]   <= '0;
      for (int k = 0; k < int'(N_HID); k++) hid_q[k] <= '0;
      for (int k = 0; k < int'(N_OUT); k++) izl_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      i_q       <= i_d;
      n_q       <= n_d;
      acc_q     <= acc_d;
      wt_drop_q <= wt_drop_d;
      x_q       <= x_d;
      hid_q     <= hid_d;
      izl_q     <= izl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wt_addr] <= wt_data;
  end

  always_comb begin
    izlaz     = '0;
    indikator = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      izlaz[k*W +: W] = izl_q[k];
      indikator[k]    = izl_q[k][W-1];
    end
  end

  assign uzorak_ready = (state_q == StIdle);
  assign izlaz_valid  = (state_q == StHold);
  assign wt_drop      = wt_drop_q;

endmodule

// File: tb/tb_neural_net_seq.sv
// Self-checking bench for neural_net_seq: directed vectors with hand-computed results,
// then random weights/features against a plain-arithmetic reference model.
module tb_neural_net_seq;

  localparam int N_IN  = 60;
  localparam int N_HID = 5;
  localparam int N_OUT = 2;
  localparam int W     = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;
  localparam int NW    = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
  localparam int AW    = $clog2(NW);
  localparam int OBASE = N_HID * (N_IN + 1);
  localparam int LAT   = NW;  // edges after the acceptance edge until izlaz_valid

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_IN*W-1:0]  uzorak;
  logic               uzorak_valid;
  logic               uzorak_ready;
  logic               wt_we;
  logic [AW-1:0]      wt_addr;
  logic [W-1:0]       wt_data;
  logic               wt_drop;
  logic [N_OUT*W-1:0] izlaz;
  logic [N_OUT-1:0]   indikator;
  logic               izlaz_valid;
  logic               izlaz_ready;

  neural_net_seq #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W(W), .FRAC(FRAC), .ACC_W(ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uzorak       (uzorak),
    .uzorak_valid (uzorak_valid),
    .uzorak_ready (uzorak_ready),
    .wt_we        (wt_we),
    .wt_addr      (wt_addr),
    .wt_data      (wt_data),
    .wt_drop      (wt_drop),
    .izlaz        (izlaz),
    .indikator    (indikator),
    .izlaz_valid  (izlaz_valid),
    .izlaz_ready  (izlaz_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int wm [NW];          // reference copy of the weight store
  int feat [N_IN];      // current feature vector
  longint exp_o [N_OUT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: straight dot products with the documented weight layout.
  function automatic void model();
    longint hid [N_HID];
    longint acc;
    for (int h = 0; h < N_HID; h++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) acc += longint'(feat[i]) * longint'(wm[h*(N_IN+1)+i]);
      acc = sat16((acc + longint'(wm[h*(N_IN+1)+N_IN]) * 256) >>> FRAC);
      hid[h] = (acc < 0) ? 0 : acc;
    end
    for (int o = 0; o < N_OUT; o++) begin
      acc = 0;
      for (int j = 0; j < N_HID; j++) acc += hid[j] * longint'(wm[OBASE+o*(N_HID+1)+j]);
      exp_o[o] = sat16((acc + longint'(wm[OBASE+o*(N_HID+1)+N_HID]) * 256) >>> FRAC);
    end
  endfunction

  task automatic wr(input int a, input int d);
    logic [31:0] av;
    logic [31:0] dv;
    av = a;
    dv = d;
    @(negedge clk);
    wt_we   = 1'b1;
    wt_addr = av[AW-1:0];
    wt_data = dv[W-1:0];
    @(posedge clk);
    #1 wt_we = 1'b0;
  endtask

  task automatic load_all();
    for (int a = 0; a < NW; a++) wr(a, wm[a]);
  endtask

  task automatic drive_feat();
    logic [31:0] fv;
    for (int i = 0; i < N_IN; i++) begin
      fv = feat[i];
      uzorak[i*W +: W] = fv[W-1:0];
    end
  endtask

  task automatic start_sample();
    @(negedge clk);
    drive_feat();
    uzorak_valid = 1'b1;
    check("ready_idle", 64'(uzorak_ready), 64'd1);
    @(posedge clk);
    #1 uzorak_valid = 1'b0;
    check("ready_busy", 64'(uzorak_ready), 64'd0);
  endtask

  task automatic wait_result();
    int n;
    n = 1;  // the #1 after acceptance already sits after edge 0
    while (n < 2000) begin
      @(negedge clk);
      if (izlaz_valid) break;
      @(posedge clk);
      n++;
    end
    check("latency", 64'(n - 1), 64'(LAT));
  endtask

  task automatic check_model(input string tag);
    logic [63:0] e;
    model();
    for (int o = 0; o < N_OUT; o++) begin
      e = 64'(exp_o[o]);
      check({tag, "_izlaz"}, 64'(izlaz[o*W +: W]), 64'(e[W-1:0]));
      check({tag, "_ind"}, 64'(indikator[o]), 64'(exp_o[o] < 0));
    end
  endtask

  task automatic consume();
    @(negedge clk);
    izlaz_ready = 1'b1;
    @(posedge clk);
    #1 izlaz_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 64'(izlaz_valid), 64'd0);
    check("ready_back", 64'(uzorak_ready), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(uzorak_ready), 64'd1);
    check({tag, "_valid"}, 64'(izlaz_valid), 64'd0);
    check({tag, "_izlaz"}, 64'(izlaz), 64'd0);
    check({tag, "_ind"}, 64'(indikator), 64'd0);
    check({tag, "_drop"}, 64'(wt_drop), 64'd0);
  endtask

  task automatic clear_all();
    for (int a = 0; a < NW; a++) wm[a] = 0;
    for (int i = 0; i < N_IN; i++) feat[i] = 0;
  endtask

  logic [N_OUT*W-1:0] held;

  initial begin
    rst_n = 1'b0;
    uzorak = '0;
    uzorak_valid = 1'b0;
    wt_we = 1'b0;
    wt_addr = '0;
    wt_data = '0;
    izlaz_ready = 1'b0;
    #23;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: h0 = 2.0, out0 = -2.0, out1 = +2.0
    clear_all();
    wm[0] = 16'h0100;
    wm[OBASE] = -256;
    wm[OBASE + N_HID + 1] = 256;
    load_all();
    feat[0] = 16'h0200;
    start_sample();
    wait_result();
    check("basic_izlaz0", 64'(izlaz[15:0]), 64'h0000_FE00);
    check("basic_izlaz1", 64'(izlaz[31:16]), 64'h0000_0200);
    check("basic_ind", 64'(indikator), 64'd1);
    consume();

    // ReLU: negative hidden value clamps to 0
    feat[0] = -512;
    start_sample();
    wait_result();
    check("relu_izlaz", 64'(izlaz), 64'd0);
    check("relu_ind", 64'(indikator), 64'd0);
    consume();

    // Saturation and bias
    clear_all();
    for (int i = 0; i < N_IN; i++) begin
      wm[i] = 32767;
      feat[i] = 32767;
    end
    wm[OBASE + N_HID + 1] = 256;
    wm[OBASE + N_HID + 1 + N_HID] = -32768;
    load_all();
    start_sample();
    wait_result();
    check("sat_izlaz1", 64'(izlaz[31:16]), 64'h0000_FFFF);
    check("sat_izlaz0", 64'(izlaz[15:0]), 64'h0000_0000);
    check("sat_ind", 64'(indikator), 64'd2);
    consume();

    // Out-of-range write in IDLE: ignored, no drop flag
    wr(NW + 50, 16'h1234);
    @(negedge clk);
    check("oor_nodrop", 64'(wt_drop), 64'd0);

    // Random weights and features against the model
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < NW; a++) wm[a] = int'($urandom_range(0, 65535)) - 32768;
      for (int a = 0; a < N_HID * (N_IN + 1); a++) wm[a] = wm[a] / 64;  // keep hidden unsaturated
      load_all();
      for (int s = 0; s < 3; s++) begin
        for (int i = 0; i < N_IN; i++) feat[i] = int'($urandom_range(0, 65535)) - 32768;
        start_sample();
        wait_result();
        check_model("rand");
        consume();
      end
    end

    // Back-pressure: result held, new sample ignored while in HOLD
    start_sample();
    wait_result();
    check_model("bp");
    held = izlaz;
    for (int i = 0; i < N_IN; i++) feat[i] = 100 + i;
    drive_feat();
    uzorak_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_stable", 64'(izlaz), 64'(held));
      check("bp_busy", 64'(uzorak_ready), 64'd0);
      check("bp_valid", 64'(izlaz_valid), 64'd1);
    end
    izlaz_ready = 1'b1;
    @(posedge clk);
    #1 izlaz_ready = 1'b0;
    uzorak_valid = 1'b0;
    @(negedge clk);
    check("bp_ready", 64'(uzorak_ready), 64'd1);
    check("bp_held_after", 64'(izlaz), 64'(held));

    // Same-edge write and sample: sample sees new weight
    wm[1] = 300;
    @(negedge clk);
    drive_feat();
    wt_we = 1'b1;
    wt_addr = AW'(1);
    wt_data = 16'd300;
    uzorak_valid = 1'b1;
    @(posedge clk);
    #1 wt_we = 1'b0;
    uzorak_valid = 1'b0;
    wait_result();
    check_model("same_edge");
    consume();

    // Busy write is dropped; mid-computation reset aborts; rerun matches
    start_sample();
    repeat (8) @(posedge clk);
    wr(3, wm[3] + 1000);
    @(negedge clk);
    check("busy_drop", 64'(wt_drop), 64'd1);
    check("busy_valid", 64'(izlaz_valid), 64'd0);
    repeat (80) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    start_sample();
    wait_result();
    check_model("rerun");
    consume();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
